// File: rtl/pulse_extender_pkg.sv
// Shared state encoding and timing defaults for the output pulse extender.
// The 10-cycle default matches the input debouncer's limit.
package pulse_extender_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pe_state_e;

  localparam int unsigned DEFAULT_LIMIT_CYCLES = 10;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_extender_event_queue_counter.sv
// Saturating up/down counter of queued events; flags an increment lost to saturation.
module event_queue_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         overflow
);

  logic [W-1:0] count_q, count_d;
  logic         overflow_q, overflow_d;

  always_comb begin
    count_d    = count_q;
    overflow_d = 1'b0;
    case ({inc, dec})
      2'b10: begin
        if (count_q == '1) overflow_d = 1'b1;
        else               count_d    = count_q + W'(1);
      end
      2'b01: begin
        if (count_q != '0) count_d = count_q - W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/pulse_extender.sv
// Turns single-cycle event strobes into pulses with a minimum high time and a
// minimum low gap; events arriving mid-pulse are queued and replayed in order.
module pulse_extender
  import pulse_extender_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = DEFAULT_LIMIT_CYCLES,
  parameter int unsigned LOW_CYCLES  = DEFAULT_LIMIT_CYCLES,
  parameter int unsigned PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              event_in,
  output logic              pin_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int unsigned     CNT_W     = $clog2(max_u(HIGH_CYCLES, LOW_CYCLES) + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CYCLES);
  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_CYCLES);

  pe_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pin_q, pin_d;
  logic             start;
  logic             consume;

  assign start = event_in | (pending != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pin_d   = pin_q;
    consume = 1'b0;
    case (state_q)
      IDLE: begin
        pin_d = 1'b0;
        if (start) begin
          state_d = HIGH;
          pin_d   = 1'b1;
          cnt_d   = CNT_ONE;
          consume = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q == HIGH_LAST) begin
          state_d = LOW;
          pin_d   = 1'b0;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      LOW: begin
        if (cnt_q == LOW_LAST) begin
          // Back-to-back restart skips IDLE so the gap is exactly LOW_CYCLES.
          if (start) begin
            state_d = HIGH;
            pin_d   = 1'b1;
            cnt_d   = CNT_ONE;
            consume = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        pin_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pin_q   <= pin_d;
    end
  end

  // A start always draws from the queue; a coincident event_in refills it.
  event_queue_counter #(
    .W(PEND_W)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .inc     (event_in),
    .dec     (consume),
    .count   (pending),
    .overflow(overflow)
  );

  assign pin_out = pin_q;
  assign busy    = (state_q != IDLE);

endmodule
